// File: rtl/des_pkg.sv
// DES shared definitions: round count, index width, FSM states,
// and the PC-1 / PC-2 bit-selection permutations (DES bit 1 = MSB).
package des_pkg;

  localparam int ROUNDS = 16;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Parity bits (8, 16, ... 64) are simply never selected.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int j = 0; j < 56; j++) begin
      r[55-j] = k[64-PC1_T[j]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) begin
      r[47-j] = cd[56-PC2_T[j]];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_key_sequencer_key_schedule.sv
// key_schedule: one combinational DES key-schedule round.
// Ports: x (C||D in), i (round 0..15), r (rotated C||D), k (PC-2 round key).
module key_schedule
  import des_pkg::*;
(
  input  logic [55:0]      x,
  input  logic [IDX_W-1:0] i,
  output logic [55:0]      r,
  output logic [47:0]      k
);

  logic [27:0] c;
  logic [27:0] d;
  logic [27:0] c_r;
  logic [27:0] d_r;
  logic        one;

  always_comb begin
    c   = x[55:28];
    d   = x[27:0];
    one = (i == IDX_W'(0)) || (i == IDX_W'(1)) ||
          (i == IDX_W'(8)) || (i == IDX_W'(15));
    if (one) begin
      c_r = {c[26:0], c[27]};
      d_r = {d[26:0], d[27]};
    end else begin
      c_r = {c[25:0], c[27:26]};
      d_r = {d[25:0], d[27:26]};
    end
    r = {c_r, d_r};
    k = pc2(r);
  end

endmodule

// File: rtl/des_key_sequencer.sv
// des_key_sequencer: generates the 16 DES round keys, one per cycle,
// buffers them and streams them forward (enc) or reverse (dec).
// Ports: clk, rst (async high); key_valid/key_ready/key/dec in;
// rk_valid/rk_ready handshake out with rk, rk_idx, rk_last.
module des_key_sequencer
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [63:0]      key,
  input  logic             dec,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [47:0]      rk,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_last
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [55:0]      cd_q, cd_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             dec_q, dec_d;
  logic [47:0]      buf_q [ROUNDS];
  logic [47:0]      buf_d [ROUNDS];
  logic             rk_valid_q, rk_valid_d;
  logic [47:0]      rk_q, rk_d;
  logic [IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic             rk_last_q, rk_last_d;

  logic [55:0]      ks_r;
  logic [47:0]      ks_k;

  key_schedule u_ks (
    .x (cd_q),
    .i (cnt_q),
    .r (ks_r),
    .k (ks_k)
  );

  function automatic logic is_last(
    input logic [IDX_W-1:0] p,
    input logic             dn
  );
    return dn ? (p == '0) : (p == IDX_MAX);
  endfunction

  always_comb begin
    state_d    = state_q;
    cd_d       = cd_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    dec_d      = dec_q;
    buf_d      = buf_q;
    rk_valid_d = rk_valid_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
    rk_last_d  = rk_last_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          cd_d    = pc1(key);
          dec_d   = dec;
          cnt_d   = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        cd_d         = ks_r;
        buf_d[cnt_q] = ks_k;
        if (cnt_q == IDX_MAX) begin
          ptr_d   = dec_q ? IDX_MAX : '0;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      EMIT: begin
        // First EMIT cycle loads the output register from the buffer.
        if (!rk_valid_q) begin
          rk_valid_d = 1'b1;
          rk_d       = buf_q[ptr_q];
          rk_idx_d   = ptr_q;
          rk_last_d  = is_last(ptr_q, dec_q);
        end else if (rk_ready) begin
          if (rk_last_q) begin
            rk_valid_d = 1'b0;
            rk_d       = '0;
            rk_idx_d   = '0;
            rk_last_d  = 1'b0;
            state_d    = IDLE;
          end else begin
            ptr_d     = dec_q ? ptr_q - IDX_W'(1)
                              : ptr_q + IDX_W'(1);
            rk_d      = buf_q[ptr_d];
            rk_idx_d  = ptr_d;
            rk_last_d = is_last(ptr_d, dec_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cd_q       <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      dec_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_q       <= '0;
      rk_idx_q   <= '0;
      rk_last_q  <= 1'b0;
      for (int n = 0; n < ROUNDS; n++) begin
        buf_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cd_q       <= cd_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      dec_q      <= dec_d;
      rk_valid_q <= rk_valid_d;
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
      rk_last_q  <= rk_last_d;
      for (int n = 0; n < ROUNDS; n++) begin
        buf_q[n] <= buf_d[n];
      end
    end
  end

  assign key_ready = (state_q == IDLE) && !rst;
  assign rk_valid  = rk_valid_q;
  assign rk        = rk_q;
  assign rk_idx    = rk_idx_q;
  assign rk_last   = rk_last_q;

endmodule

// File: tb/tb_des_key_sequencer.sv
// Testbench for des_key_sequencer: known vectors, random keys and
// stalls against a table-level DES key-schedule model, resets mid-run.
module tb_des_key_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [63:0] key = '0;
  logic        dec = 1'b0;
  logic        rk_valid;
  logic        rk_ready = 1'b0;
  logic [47:0] rk;
  logic [3:0]  rk_idx;
  logic        rk_last;

  des_key_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .dec       (dec),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int m_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int m_sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Round key K(round+1): halves rotated by the cumulative shift total.
  function automatic logic [47:0] model_rk(input logic [63:0] k,
                                           input int round);
    bit kb [65];
    bit c [28];
    bit d [28];
    bit cd [57];
    int s;
    logic [47:0] res;
    for (int n = 1; n <= 64; n++) kb[n] = k[64-n];
    for (int n = 0; n < 28; n++) begin
      c[n] = kb[m_pc1[n]];
      d[n] = kb[m_pc1[n+28]];
    end
    s = 0;
    for (int n = 0; n <= round; n++) s += m_sh[n];
    cd[0] = 1'b0;
    for (int n = 0; n < 28; n++) begin
      cd[n+1]  = c[(n+s)%28];
      cd[n+29] = d[(n+s)%28];
    end
    res = '0;
    for (int n = 1; n <= 48; n++) res[48-n] = cd[m_pc2[n-1]];
    return res;
  endfunction

  // ---------------- beat monitor ----------------
  typedef struct {
    logic [3:0]  idx;
    logic [47:0] rk;
    logic        last;
  } beat_t;

  beat_t       bq[$];
  bit          mon_en = 1'b0;
  bit          got_last = 1'b0;
  bit          prev_stall = 1'b0;
  logic [47:0] p_rk;
  logic [3:0]  p_idx;
  logic        p_last;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold",
              {rk_valid, rk_last, rk_idx, 10'd0, rk},
              {1'b1, p_last, p_idx, 10'd0, p_rk});
      end
      if (rk_valid && rk_ready) begin
        bq.push_back('{idx: rk_idx, rk: rk, last: rk_last});
        if (rk_last) got_last = 1'b1;
      end
      prev_stall = rk_valid && !rk_ready;
      p_rk   = rk;
      p_idx  = rk_idx;
      p_last = rk_last;
    end
  end

  // ---------------- reset helper ----------------
  task automatic do_reset_mid(input string nm);
    int seen;
    mon_en = 1'b0;
    rk_ready = 1'b1;
    rst = 1'b1;
    #1;
    check({nm, "_outs0"}, {rk_valid, rk_last, rk_idx, rk},
          64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check({nm, "_kready"}, key_ready, 1);
    seen = 0;
    for (int n = 0; n < 24; n++) begin
      @(posedge clk);
      #1;
      if (rk_valid) seen++;
    end
    check({nm, "_no_beats"}, seen, 0);
    rk_ready = 1'b0;
  endtask

  // ---------------- one key sequence ----------------
  task automatic run_seq(input logic [63:0] k, input logic d,
                         input bit rnd, input bit chk_cd,
                         input bit inject, input int ab_cnt,
                         input int ab_idx);
    int n;
    int m;
    bq.delete();
    got_last = 1'b0;
    mon_en = 1'b1;
    key = k;
    dec = d;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key = {$urandom, $urandom};
    dec = ~d;
    if (chk_cd) check("cd_pc1", dut.cd_q, 64'hF0CCAAF556678F);
    n = 0;
    while (!rk_valid && n < 40) begin
      rk_ready = rnd ? 1'($urandom % 2) : 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (chk_cd && n == 1)
        check("cd_round0", dut.cd_q, 64'hE19955FAACCF1E);
      if (inject && n == 5) begin
        key_valid = 1'b1;
        check("kready_gen", key_ready, 0);
      end else begin
        key_valid = 1'b0;
      end
      if (ab_cnt == n) begin
        check("abort_cnt", dut.cnt_q, 64'(ab_cnt));
        do_reset_mid("rst_gen");
        return;
      end
    end
    check("latency", n, 17);
    m = 0;
    while (!got_last && m < 300) begin
      if (ab_idx >= 0 && rk_valid && rk_idx == 4'(ab_idx)) begin
        do_reset_mid("rst_emit");
        return;
      end
      if (inject && m == 3) begin
        key_valid = 1'b1;
        check("kready_emit", key_ready, 0);
      end else begin
        key_valid = 1'b0;
      end
      rk_ready = rnd ? 1'($urandom % 2) : 1'b1;
      @(posedge clk);
      #1;
      m++;
    end
    key_valid = 1'b0;
    rk_ready = 1'b0;
    check("got_last", got_last, 1);
    check("end_vld_kr", {rk_valid, key_ready}, 2'b01);
    check("beat_count", bq.size(), 16);
    for (int b = 0; b < bq.size() && b < 16; b++) begin
      int r;
      r = d ? 15 - b : b;
      check("seq_beat",
            {bq[b].last, bq[b].idx, bq[b].rk},
            {(b == 15), 4'(r), model_rk(k, r)});
    end
    mon_en = 1'b0;
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          beat;
    logic [3:0]  idx;
    logic [47:0] rk;
    logic        last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{64'h133457799BBCDFF1, 0, 0,  0, 48'h1B02EFFC7072, 0};
    vecs[1] = '{64'h133457799BBCDFF1, 0, 1,  1, 48'h79AED9DBC9E5, 0};
    vecs[2] = '{64'h133457799BBCDFF1, 0, 15, 15, 48'hCB3D8B0E17F5, 1};
    vecs[3] = '{64'h133457799BBCDFF1, 1, 0, 15, 48'hCB3D8B0E17F5, 0};
    vecs[4] = '{64'h133457799BBCDFF1, 1, 14, 1, 48'h79AED9DBC9E5, 0};
    vecs[5] = '{64'h133457799BBCDFF1, 1, 15, 0, 48'h1B02EFFC7072, 1};

    #2;
    check("rst_outs", {rk_valid, rk_last, rk_idx, rk}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_kready", key_ready, 1);
    check("rst_vld", rk_valid, 0);

    for (int v = 0; v < 6; v++) begin
      run_seq(vecs[v].key, vecs[v].dec, 0, (v == 0), 0, -1, -1);
      if (bq.size() > vecs[v].beat) begin
        check("kat",
              {bq[vecs[v].beat].last, bq[vecs[v].beat].idx,
               bq[vecs[v].beat].rk},
              {vecs[v].last, vecs[v].idx, vecs[v].rk});
      end else begin
        check("kat_missing", bq.size(), 64'(vecs[v].beat + 1));
      end
    end

    run_seq(64'h133457799BBCDFF1, 0, 1, 0, 0, -1, -1);
    for (int t = 0; t < 5; t++) begin
      run_seq({$urandom, $urandom}, 1'($urandom % 2), 1, 0, 0, -1, -1);
    end

    run_seq(64'h0E329232EA6D0D73, 0, 1, 0, 1, -1, -1);
    run_seq(64'h0E329232EA6D0D73, 1, 0, 0, 1, -1, -1);

    run_seq(64'h133457799BBCDFF1, 0, 0, 0, 0, 7, -1);
    run_seq(64'h133457799BBCDFF1, 0, 0, 0, 0, -1, -1);
    run_seq(64'h133457799BBCDFF1, 0, 0, 0, 0, -1, 5);
    run_seq(64'h133457799BBCDFF1, 1, 0, 1, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
